// File: rtl/instruction_decoder.sv
// Opcode decoder: 4-bit opcode to one-hot strobes {load,add,bitand,sub,input_out,output_out,jump,jump_cond}.
// Latency 1 cycle, registered outputs; the optional illegal flag is built when DECODER_ILLEGAL_FLAG_EN is defined.
// No backpressure: en=0 holds the outputs, and sync active-high rst clears them with priority over en.
module instruction_decoder #(
    parameter int N_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_BITS-1:0] a_in,
    output logic              load,
    output logic              add,
    output logic              bitand,
    output logic              sub,
    output logic              input_out,
    output logic              output_out,
    output logic              jump,
    output logic              jump_cond
`ifdef DECODER_ILLEGAL_FLAG_EN
    ,
    output logic              illegal
`endif
);

    logic [7:0] strobes_d;
    logic [7:0] strobes_q;

    // Case items are compared with 4-state equality, so any X/Z opcode falls to the default (invalid).
    always_comb begin
        strobes_d = 8'b0000_0000;
        case (a_in)
            4'b0000: strobes_d = 8'b1000_0000;
            4'b0100: strobes_d = 8'b0100_0000;
            4'b0001: strobes_d = 8'b0010_0000;
            4'b0110: strobes_d = 8'b0001_0000;
            4'b1010: strobes_d = 8'b0000_1000;
            4'b1110: strobes_d = 8'b0000_0100;
            4'b1000: strobes_d = 8'b0000_0010;
            4'b1001: strobes_d = 8'b0000_0001;
            default: strobes_d = 8'b0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobes_q <= 8'b0000_0000;
        end else if (en) begin
            strobes_q <= strobes_d;
        end
    end

    assign load       = strobes_q[7];
    assign add        = strobes_q[6];
    assign bitand     = strobes_q[5];
    assign sub        = strobes_q[4];
    assign input_out  = strobes_q[3];
    assign output_out = strobes_q[2];
    assign jump       = strobes_q[1];
    assign jump_cond  = strobes_q[0];

`ifdef DECODER_ILLEGAL_FLAG_EN
    logic illegal_d;
    logic illegal_q;

    // Derived from the decoded strobes so the flag can never disagree with them.
    assign illegal_d = (strobes_d == 8'b0000_0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (en) begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// Table-driven bench for instruction_decoder plus a random all-opcode sweep.
module tb_instruction_decoder;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] a;
        logic [7:0] exp;
        logic       exp_ill;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] a_in;
    logic       load, add, bitand, sub, input_out, output_out, jump, jump_cond;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    vec_t       vecs[$];
    logic [7:0] exp_map [16];
    logic       ill_map [16];

    instruction_decoder #(.N_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .a_in       (a_in),
        .load       (load),
        .add        (add),
        .bitand     (bitand),
        .sub        (sub),
        .input_out  (input_out),
        .output_out (output_out),
        .jump       (jump),
        .jump_cond  (jump_cond)
`ifdef DECODER_ILLEGAL_FLAG_EN
        ,
        .illegal    (illegal)
`endif
    );

`ifndef DECODER_ILLEGAL_FLAG_EN
    assign illegal = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic logic [7:0] grouped();
        return {load, add, bitand, sub, input_out, output_out, jump, jump_cond};
    endfunction

    // Drive away from the rising edge, then sample 1 time unit after it.
    task automatic step(input logic r, input logic e, input logic [3:0] a);
        @(negedge clk);
        rst  = r;
        en   = e;
        a_in = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp, input logic exp_ill);
        logic [7:0] got;
        got = grouped();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: strobes got %b expected %b", name, got, exp);
        end
        checks++;
        if ($countones(got) > 1) begin
            errors++;
            $display("FAIL %s onehot: strobes got %b expected at most one bit set", name, got);
        end
`ifdef DECODER_ILLEGAL_FLAG_EN
        checks++;
        if (illegal !== exp_ill) begin
            errors++;
            $display("FAIL %s illegal: got %b expected %b", name, illegal, exp_ill);
        end
`endif
    endtask

    task automatic add_vec(input logic r, input logic e, input logic [3:0] a,
                           input logic [7:0] x, input logic xi, input string n);
        vec_t v;
        v.rst = r; v.en = e; v.a = a; v.exp = x; v.exp_ill = xi; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] op;
        logic [3:0] invalid_ops [8];

        rst  = 1'b1;
        en   = 1'b0;
        a_in = 4'b0000;

        for (int i = 0; i < 16; i++) begin
            exp_map[i] = 8'h00;
            ill_map[i] = 1'b1;
        end
        exp_map[4'b0000] = 8'b1000_0000;
        exp_map[4'b0100] = 8'b0100_0000;
        exp_map[4'b0001] = 8'b0010_0000;
        exp_map[4'b0110] = 8'b0001_0000;
        exp_map[4'b1010] = 8'b0000_1000;
        exp_map[4'b1110] = 8'b0000_0100;
        exp_map[4'b1000] = 8'b0000_0010;
        exp_map[4'b1001] = 8'b0000_0001;
        ill_map[4'b0000] = 1'b0; ill_map[4'b0100] = 1'b0;
        ill_map[4'b0001] = 1'b0; ill_map[4'b0110] = 1'b0;
        ill_map[4'b1010] = 1'b0; ill_map[4'b1110] = 1'b0;
        ill_map[4'b1000] = 1'b0; ill_map[4'b1001] = 1'b0;

        // Reset with a valid opcode presented, then release.
        add_vec(1, 1, 4'b0100, 8'b0000_0000, 0, "reset0");
        add_vec(1, 1, 4'b0100, 8'b0000_0000, 0, "reset1");
        add_vec(0, 1, 4'b0100, 8'b0100_0000, 0, "post_reset_add");
        // Valid sweep.
        add_vec(0, 1, 4'b0000, 8'b1000_0000, 0, "load");
        add_vec(0, 1, 4'b0100, 8'b0100_0000, 0, "add");
        add_vec(0, 1, 4'b0001, 8'b0010_0000, 0, "bitand");
        add_vec(0, 1, 4'b0110, 8'b0001_0000, 0, "sub");
        add_vec(0, 1, 4'b1010, 8'b0000_1000, 0, "input");
        add_vec(0, 1, 4'b1110, 8'b0000_0100, 0, "output");
        add_vec(0, 1, 4'b1000, 8'b0000_0010, 0, "jump");
        add_vec(0, 1, 4'b1001, 8'b0000_0001, 0, "jump_cond");
        // Invalid sweep.
        invalid_ops = '{4'b0010, 4'b0011, 4'b0101, 4'b0111, 4'b1011, 4'b1100, 4'b1101, 4'b1111};
        foreach (invalid_ops[i])
            add_vec(0, 1, invalid_ops[i], 8'b0000_0000, 1, $sformatf("invalid_%b", invalid_ops[i]));
        // Enable hold.
        add_vec(0, 1, 4'b1110, 8'b0000_0100, 0, "hold_load_output");
        add_vec(0, 0, 4'b1000, 8'b0000_0100, 0, "hold0");
        add_vec(0, 0, 4'b1000, 8'b0000_0100, 0, "hold1");
        add_vec(0, 0, 4'b1000, 8'b0000_0100, 0, "hold2");
        add_vec(0, 1, 4'b1000, 8'b0000_0010, 0, "hold_release");
        // Invalid then hold: the illegal flag must hold too.
        add_vec(0, 1, 4'b1111, 8'b0000_0000, 1, "inv_before_hold");
        add_vec(0, 0, 4'b0000, 8'b0000_0000, 1, "inv_hold");
        // Mid-stream reset.
        add_vec(0, 1, 4'b0000, 8'b1000_0000, 0, "ms_load");
        add_vec(0, 1, 4'b1001, 8'b0000_0001, 0, "ms_jc");
        add_vec(1, 1, 4'b0000, 8'b0000_0000, 0, "ms_reset");
        add_vec(0, 1, 4'b1001, 8'b0000_0001, 0, "ms_jc_resume");
        add_vec(0, 1, 4'b0000, 8'b1000_0000, 0, "ms_load_resume");
        // Reset overrides en=0 hold.
        add_vec(1, 0, 4'b0100, 8'b0000_0000, 0, "reset_en0");
        add_vec(0, 0, 4'b0100, 8'b0000_0000, 0, "reset_en0_hold");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].a);
            check(vecs[i].name, vecs[i].exp, vecs[i].exp_ill);
        end

        // a_in wiggling between edges must not reach the outputs.
        step(0, 1, 4'b0110);
        #2 a_in = 4'b0000;
        #1 a_in = 4'b1001;
        check("mid_cycle_change", 8'b0001_0000, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            op = 4'($urandom_range(0, 15));
            step(0, 1, op);
            check($sformatf("rand_%0d_%b", i, op), exp_map[op], ill_map[op]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
